// File: rtl/producer_consumer_arbiter.sv
// producer_consumer_arbiter: round-robin frame arbiter sharing one core between NUM_REQ requester streams
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_data/req_ready   requester input streams, requester i at req_data[i*DATA_WIDTH +: DATA_WIDTH]
//   input_fifo_valid/ready, input_fifo     granted stream towards the core
//   output_fifo_valid/ready, output_fifo   core results
//   rsp_valid/rsp_ready, rsp_data          results routed back to the owning requester
//   grant_id, busy                         current/last grant, high while streaming a frame
module producer_consumer_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 100,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          input_fifo_valid,
    input  logic                          input_fifo_ready,
    output logic [DATA_WIDTH-1:0]         input_fifo,
    input  logic                          output_fifo_valid,
    output logic                          output_fifo_ready,
    input  logic [DATA_WIDTH-1:0]         output_fifo,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [1:0]                    grant_id,
    output logic                          busy
);
    localparam int CW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int OW = $clog2(TAG_DEPTH + 1);
    typedef enum logic {IDLE, STREAM} state_t;
    state_t          state;
    logic [1:0]      last_grant, pick, head;
    logic [CW-1:0]   beat;
    logic [1:0]      tag_mem [TAG_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [OW-1:0]   count;
    logic            found, push, pop, hs, empty, full;
    // first valid requester after last_grant, wrapping; lowest distance wins
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
                found = 1'b1;
                pick  = 2'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end
    assign empty = count == '0;
    assign full  = count == OW'(TAG_DEPTH);
    // a pop in the same cycle does not free a slot for this cycle's grant
    assign push  = state == IDLE && found && !full;
    assign head  = tag_mem[rd_ptr];
    assign hs    = input_fifo_valid && input_fifo_ready;
    assign pop   = output_fifo_valid && output_fifo_ready;
    always_comb begin
        busy              = state == STREAM;
        req_ready         = '0;
        input_fifo_valid  = 1'b0;
        input_fifo        = '0;
        rsp_valid         = '0;
        output_fifo_ready = 1'b0;
        rsp_data          = empty ? '0 : output_fifo;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (busy && grant_id == 2'(i)) begin
                input_fifo_valid = req_valid[i];
                input_fifo       = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready[i]     = input_fifo_ready;
            end
            if (!empty && head == 2'(i)) begin
                rsp_valid[i]      = output_fifo_valid;
                output_fifo_ready = rsp_ready[i];
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= 2'(NUM_REQ - 1);
            beat       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            if (state == IDLE) begin
                if (push) begin
                    grant_id <= pick;
                    beat     <= '0;
                    state    <= STREAM;
                end
            end else if (hs) begin
                beat <= beat + CW'(1);
                if (beat == CW'(FRAME_LEN - 1)) begin
                    state      <= IDLE;
                    last_grant <= grant_id;
                end
            end
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + OW'(push) - OW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr] <= pick;
    end
endmodule

// File: tb/tb_producer_consumer_arbiter.sv
// tb_producer_consumer_arbiter: directed bench with a summing core model and per-requester counting sources
module tb_producer_consumer_arbiter;
    localparam int NR = 2;
    localparam int DW = 32;
    localparam int FL = 100;
    localparam int TD = 2;
    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     rsp_ready = '1;
    logic [NR-1:0]     req_ready, rsp_valid;
    logic [NR*DW-1:0]  req_data;
    logic              input_fifo_valid, output_fifo_valid, output_fifo_ready, busy;
    logic              input_fifo_ready = 1'b1;
    logic [DW-1:0]     input_fifo, output_fifo, rsp_data;
    logic [1:0]        grant_id;
    int                checks = 0;
    int                errors = 0;
    producer_consumer_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FRAME_LEN(FL), .TAG_DEPTH(TD)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .input_fifo_valid(input_fifo_valid), .input_fifo_ready(input_fifo_ready), .input_fifo(input_fifo),
        .output_fifo_valid(output_fifo_valid), .output_fifo_ready(output_fifo_ready), .output_fifo(output_fifo),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .grant_id(grant_id), .busy(busy)
    );
    always #5 clk = ~clk;
    // requester sources: frame n of requester i carries base[i] + 200*n + 0..99
    int base [NR];
    int hs_cnt [NR];
    always_comb
        for (int i = 0; i < NR; i++)
            req_data[i*DW +: DW] = DW'(base[i] + (hs_cnt[i] / FL) * 200 + hs_cnt[i] % FL);
    always @(posedge clk or negedge reset)
        for (int i = 0; i < NR; i++)
            if (!reset) hs_cnt[i] <= 0;
            else if (req_valid[i] && req_ready[i]) hs_cnt[i] <= hs_cnt[i] + 1;
    // core model: sums FL words per frame, results queued in order
    logic [DW-1:0] acc;
    int            beats, res_wr, res_rd;
    logic [DW-1:0] res_mem [8];
    assign output_fifo_valid = res_wr != res_rd;
    assign output_fifo       = res_mem[res_rd % 8];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0; beats <= 0; res_wr <= 0; res_rd <= 0;
        end else begin
            if (input_fifo_valid && input_fifo_ready) begin
                if (beats == FL - 1) begin
                    res_mem[res_wr % 8] <= acc + input_fifo;
                    res_wr <= res_wr + 1;
                    acc <= '0;
                    beats <= 0;
                end else begin
                    acc <= acc + input_fifo;
                    beats <= beats + 1;
                end
            end
            if (output_fifo_valid && output_fifo_ready) res_rd <= res_rd + 1;
        end
    end
    // monitors: delivered results, grant sequence, busy and rsp_valid[1] cycle counts
    int       rsp_who [$];
    int       rsp_val [$];
    int       glog [$];
    logic     busy_d = 1'b0;
    int       busy_cycles = 0;
    int       rv1_cycles = 0;
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++)
            if (rsp_valid[i] && rsp_ready[i]) begin
                rsp_who.push_back(i);
                rsp_val.push_back(int'(rsp_data));
            end
        busy_d <= busy;
        if (busy && !busy_d) glog.push_back(int'(grant_id));
        if (busy) busy_cycles <= busy_cycles + 1;
        if (rsp_valid[1]) rv1_cycles <= rv1_cycles + 1;
    end
    task automatic do_reset();
        reset = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        input_fifo_ready = 1'b1;
        base[0] = 0;
        base[1] = 100;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, input_fifo_valid, output_fifo_ready, rsp_valid, busy, grant_id} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rr=%b ifv=%b ofr=%b rv=%b busy=%b gid=%0d, need all 0",
                     req_ready, input_fifo_valid, output_fifo_ready, rsp_valid, busy, grant_id);
        end
        do_reset();
        checks++;
        if ({req_ready, input_fifo_valid, busy} !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: got rr=%b ifv=%b busy=%b, need 0", req_ready, input_fifo_valid, busy);
        end
    endtask
    task automatic test_single();
        int r0, g0, b0, v0, n;
        do_reset();
        r0 = rsp_val.size(); g0 = glog.size(); b0 = busy_cycles; v0 = rv1_cycles;
        req_valid = 2'b01;
        for (n = 0; n < 300 && hs_cnt[0] < FL; n++) @(negedge clk);
        req_valid = '0;
        for (n = 0; n < 20 && rsp_val.size() == r0; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_val.size() != r0 + 1) begin
            errors++;
            $display("FAIL single_count: got %0d results, need 1", rsp_val.size() - r0);
        end else begin
            checks++;
            if (rsp_who[r0] != 0 || rsp_val[r0] != 4950) begin
                errors++;
                $display("FAIL single_result: got req%0d=%0d, need req0=4950", rsp_who[r0], rsp_val[r0]);
            end
        end
        checks++;
        if (busy_cycles - b0 != 100) begin
            errors++;
            $display("FAIL single_busy: got %0d busy cycles, need 100", busy_cycles - b0);
        end
        checks++;
        if (rv1_cycles != v0) begin
            errors++;
            $display("FAIL single_rv1: got %0d cycles of rsp_valid[1], need 0", rv1_cycles - v0);
        end
        checks++;
        if (glog.size() != g0 + 1 || glog[g0] != 0) begin
            errors++;
            $display("FAIL single_grant: got %0d grants first=%0d, need 1 grant to 0", glog.size() - g0,
                     glog.size() > g0 ? glog[g0] : -1);
        end
    endtask
    task automatic test_alternate();
        int r0, g0, n;
        int exp_who [4] = '{0, 1, 0, 1};
        int exp_val [4] = '{4950, 14950, 24950, 34950};
        do_reset();
        r0 = rsp_val.size(); g0 = glog.size();
        req_valid = 2'b11;
        for (n = 0; n < 1000 && req_valid != '0; n++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) if (hs_cnt[i] >= 2 * FL) req_valid[i] = 1'b0;
        end
        for (n = 0; n < 50 && rsp_val.size() < r0 + 4; n++) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (glog.size() <= g0 + k || glog[g0+k] != exp_who[k]) begin
                errors++;
                $display("FAIL alt_grant%0d: got %0d, need %0d", k, glog.size() > g0 + k ? glog[g0+k] : -1, exp_who[k]);
            end
            checks++;
            if (rsp_val.size() <= r0 + k || rsp_who[r0+k] != exp_who[k] || rsp_val[r0+k] != exp_val[k]) begin
                errors++;
                $display("FAIL alt_result%0d: got req%0d=%0d, need req%0d=%0d", k,
                         rsp_val.size() > r0 + k ? rsp_who[r0+k] : -1, rsp_val.size() > r0 + k ? rsp_val[r0+k] : -1,
                         exp_who[k], exp_val[k]);
            end
        end
    endtask
    task automatic test_backpressure();
        int r0, n, bad;
        do_reset();
        rsp_ready = 2'b01;
        req_valid = 2'b11;
        for (n = 0; n < 500 && !rsp_valid[1]; n++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) if (hs_cnt[i] >= FL) req_valid[i] = 1'b0;
        end
        checks++;
        if (rsp_valid !== 2'b10) begin
            errors++;
            $display("FAIL bp_valid: got rsp_valid=%b, need 10", rsp_valid);
        end
        bad = 0;
        for (n = 0; n < 50; n++) begin
            if (output_fifo_ready !== 1'b0 || rsp_valid !== 2'b10 || rsp_data !== 32'd14950) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable cycles (ofr=%b data=%0d), need 0", bad, output_fifo_ready, rsp_data);
        end
        r0 = rsp_val.size();
        rsp_ready = 2'b11;
        @(negedge clk);
        checks++;
        if (rsp_val.size() != r0 + 1 || rsp_who[r0] != 1 || rsp_val[r0] != 14950) begin
            errors++;
            $display("FAIL bp_release: got %0d results last=%0d, need req1=14950", rsp_val.size() - r0,
                     rsp_val.size() > r0 ? rsp_val[r0] : -1);
        end
    endtask
    task automatic test_tag_full();
        int g0, n;
        do_reset();
        g0 = glog.size();
        rsp_ready = '0;
        req_valid = 2'b11;
        for (n = 0; n < 500 && req_valid != '0; n++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) if (hs_cnt[i] >= FL) req_valid[i] = 1'b0;
        end
        req_valid = 2'b01;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL full_block: got busy=%b req_ready=%b, need 0/00", busy, req_ready);
        end
        checks++;
        if (glog.size() - g0 != 2) begin
            errors++;
            $display("FAIL full_grants: got %0d grants, need 2", glog.size() - g0);
        end
        rsp_ready = 2'b01;
        for (n = 0; n < 20 && !busy; n++) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL full_unblock: got busy=%b grant=%0d, need 1/0", busy, grant_id);
        end
        checks++;
        if (output_fifo_ready !== 1'b0 || rsp_valid !== 2'b10) begin
            errors++;
            $display("FAIL full_head: got ofr=%b rsp_valid=%b, need 0/10", output_fifo_ready, rsp_valid);
        end
    endtask
    task automatic test_stall();
        int r0, n, bad;
        do_reset();
        r0 = rsp_val.size();
        req_valid = 2'b01;
        for (n = 0; n < 200 && hs_cnt[0] < 50; n++) @(negedge clk);
        req_valid = 2'b10;
        bad = 0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (busy !== 1'b1 || grant_id !== 2'd0 || req_ready[1] !== 1'b0 || input_fifo_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || hs_cnt[0] != 50 || hs_cnt[1] != 0) begin
            errors++;
            $display("FAIL stall_lock: got %0d bad cycles hs=%0d/%0d, need 0 and 50/0", bad, hs_cnt[0], hs_cnt[1]);
        end
        req_valid = 2'b11;
        for (n = 0; n < 200 && hs_cnt[0] < FL; n++) @(negedge clk);
        req_valid[0] = 1'b0;
        for (n = 0; n < 20 && !(busy && grant_id == 2'd1); n++) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL stall_next: got busy=%b grant=%0d, need 1/1", busy, grant_id);
        end
        checks++;
        if (rsp_val.size() <= r0 || rsp_who[r0] != 0 || rsp_val[r0] != 4950) begin
            errors++;
            $display("FAIL stall_sum: got %0d, need req0=4950", rsp_val.size() > r0 ? rsp_val[r0] : -1);
        end
        for (n = 0; n < 200 && hs_cnt[1] < FL; n++) @(negedge clk);
        req_valid = '0;
        for (n = 0; n < 20 && rsp_val.size() < r0 + 2; n++) @(negedge clk);
        checks++;
        if (rsp_val.size() < r0 + 2 || rsp_who[r0+1] != 1 || rsp_val[r0+1] != 14950) begin
            errors++;
            $display("FAIL stall_req1: got %0d, need req1=14950", rsp_val.size() > r0 + 1 ? rsp_val[r0+1] : -1);
        end
    endtask
    task automatic test_reset_mid();
        int r0, g0, n;
        do_reset();
        req_valid = 2'b01;
        for (n = 0; n < 200 && hs_cnt[0] < 50; n++) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({req_ready, input_fifo_valid, output_fifo_ready, rsp_valid, busy, grant_id} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got rr=%b ifv=%b ofr=%b rv=%b busy=%b gid=%0d, need all 0",
                     req_ready, input_fifo_valid, output_fifo_ready, rsp_valid, busy, grant_id);
        end
        @(negedge clk);
        r0 = rsp_val.size(); g0 = glog.size();
        req_valid = 2'b11;
        reset = 1'b1;
        for (n = 0; n < 300 && hs_cnt[0] < FL; n++) @(negedge clk);
        req_valid = '0;
        for (n = 0; n < 20 && rsp_val.size() == r0; n++) @(negedge clk);
        checks++;
        if (glog.size() <= g0 || glog[g0] != 0) begin
            errors++;
            $display("FAIL midreset_grant: got %0d, need 0", glog.size() > g0 ? glog[g0] : -1);
        end
        checks++;
        if (rsp_val.size() != r0 + 1 || rsp_who[r0] != 0 || rsp_val[r0] != 4950) begin
            errors++;
            $display("FAIL midreset_sum: got %0d results first=%0d, need req0=4950", rsp_val.size() - r0,
                     rsp_val.size() > r0 ? rsp_val[r0] : -1);
        end
    endtask
    initial begin
        base[0] = 0;
        base[1] = 100;
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_tag_full();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
